// File: rtl/recognizer_arbiter.sv
// Two-channel arbiter that feeds symbol sessions into a shared sequence recognizer
// and reports each session's verdict, symbol count and owning channel.
//
// state   | meaning
// IDLE    | waiting for a requester; grant chosen here
// CLEAR   | one-cycle recognizer clear, session counters reset
// FEED    | granted channel ready; next symbol captured
// STROBE  | one-cycle strobe of the captured symbol
// CHECK   | recognizer verdict sampled
// DRAIN   | verdict known, remaining symbols swallowed up to last
// REPORT  | one-cycle result pulse
module recognizer_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [6:0] req0_sym,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_sym,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [6:0] rec_sym,
  output logic       rec_strobe,
  output logic       rec_reset,
  input  logic [3:0] rec_state,
  output logic       res_valid,
  output logic       res_ch,
  output logic [2:0] res_code,
  output logic [7:0] res_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_ACC_A = 3'b001;
  localparam logic [2:0] CODE_ACC_B = 3'b010;
  localparam logic [2:0] CODE_REJ = 3'b011;
  localparam logic [2:0] CODE_INCOMP = 3'b100;
  localparam logic [2:0] CODE_TMO = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_STROBE, S_CHECK, S_DRAIN, S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_ch_q, last_ch_d;
  logic [6:0]    sym_q, sym_d;
  logic          last_q, last_d;
  logic [7:0]    count_q, count_d;
  logic [2:0]    code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_ch_q, res_ch_d;
  logic [2:0]    res_code_q, res_code_d;
  logic [7:0]    res_count_q, res_count_d;

  logic       g_valid;
  logic [6:0] g_sym;
  logic       g_last;
  logic       tmo_hit;

  assign g_valid = grant_q ? req1_valid : req0_valid;
  assign g_sym   = grant_q ? req1_sym : req0_sym;
  assign g_last  = grant_q ? req1_last : req0_last;
  assign tmo_hit = (tmo_q <= TW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      last_ch_q   <= 1'b1;  // "last served = ch1" makes ch0 win the first tie
      sym_q       <= '0;
      last_q      <= 1'b0;
      count_q     <= '0;
      code_q      <= CODE_NONE;
      tmo_q       <= '0;
      res_ch_q    <= 1'b0;
      res_code_q  <= CODE_NONE;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ch_q   <= last_ch_d;
      sym_q       <= sym_d;
      last_q      <= last_d;
      count_q     <= count_d;
      code_q      <= code_d;
      tmo_q       <= tmo_d;
      res_ch_q    <= res_ch_d;
      res_code_q  <= res_code_d;
      res_count_q <= res_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ch_d   = last_ch_q;
    sym_d       = sym_q;
    last_d      = last_q;
    count_d     = count_q;
    code_d      = code_q;
    tmo_d       = tmo_q;
    res_ch_d    = res_ch_q;
    res_code_d  = res_code_q;
    res_count_d = res_count_q;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? ~last_ch_q : req1_valid;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        code_d  = CODE_NONE;
        tmo_d   = TMO_LOAD;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (g_valid) begin
          sym_d   = g_sym;
          last_d  = g_last;
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          tmo_d   = TMO_LOAD;
          state_d = S_STROBE;
        end else if (tmo_hit) begin
          code_d  = CODE_TMO;
          state_d = S_REPORT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_STROBE: state_d = S_CHECK;
      S_CHECK: begin
        // unlisted recognizer codes fall through as "still in progress"
        case (rec_state)
          4'b1001: code_d = CODE_ACC_A;
          4'b1010: code_d = CODE_ACC_B;
          4'b1000: code_d = CODE_REJ;
          default: code_d = CODE_NONE;
        endcase
        if (code_d != CODE_NONE) begin
          state_d = last_q ? S_REPORT : S_DRAIN;
        end else if (last_q) begin
          code_d  = CODE_INCOMP;
          state_d = S_REPORT;
        end else begin
          state_d = S_FEED;
        end
      end
      S_DRAIN: begin
        if (g_valid) begin
          tmo_d = TMO_LOAD;
          if (g_last) state_d = S_REPORT;
        end else if (tmo_hit) begin
          code_d  = CODE_TMO;
          state_d = S_REPORT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_REPORT: begin
        last_ch_d = grant_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // result registers load on entry to REPORT so they are stable during the pulse
    if (state_d == S_REPORT && state_q != S_REPORT) begin
      res_ch_d    = grant_q;
      res_code_d  = code_d;
      res_count_d = count_d;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rec_strobe = 1'b0;
    res_valid  = 1'b0;
    rec_reset  = reset;
    rec_sym    = '0;
    res_ch     = 1'b0;
    res_code   = '0;
    res_count  = '0;
    if (!reset) begin
      req0_ready = (state_q == S_FEED || state_q == S_DRAIN) && !grant_q;
      req1_ready = (state_q == S_FEED || state_q == S_DRAIN) && grant_q;
      rec_strobe = (state_q == S_STROBE);
      res_valid  = (state_q == S_REPORT);
      rec_reset  = (state_q == S_CLEAR);
      rec_sym    = sym_q;
      res_ch     = res_ch_q;
      res_code   = res_code_q;
      res_count  = res_count_q;
    end
  end

endmodule

// File: tb/tb_recognizer_arbiter.sv
// Session-level bench: a tiny recognizer model answers strobes, expected results and
// strobed symbols are queued when a session is driven and compared as the DUT emits them.
module tb_recognizer_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_sym = '0, req1_sym = '0;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [6:0] rec_sym;
  logic       rec_strobe, rec_reset;
  logic [3:0] rec_state = 4'b0000;
  logic       res_valid, res_ch;
  logic [2:0] res_code;
  logic [7:0] res_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  recognizer_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_sym(req0_sym), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sym(req1_sym), .req1_last(req1_last), .req1_ready(req1_ready),
    .rec_sym(rec_sym), .rec_strobe(rec_strobe), .rec_reset(rec_reset), .rec_state(rec_state),
    .res_valid(res_valid), .res_ch(res_ch), .res_code(res_code), .res_count(res_count)
  );

  typedef struct packed {
    logic        ch;
    logic [2:0]  n;
    logic [2:0]  ns;
    logic [6:0]  s0, s1, s2;
    logic [3:0]  t0, t1;
    logic [2:0]  code;
    logic [7:0]  cnt;
  } sess_t;

  sess_t tbl[5];

  logic [11:0] exp_res[$];
  logic [6:0]  exp_sym[$];
  logic [3:0]  rec_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Recognizer model plus output monitor, both sampled on the falling edge.
  logic        clr_seen = 1'b0, prev_strobe = 1'b0, sym_pend = 1'b0, held_ok = 1'b0;
  logic [6:0]  held_sym = '0;
  logic [11:0] held_res = '0;
  always @(negedge clk) begin
    if (rec_reset) rec_state = 4'b0000;
    else if (rec_strobe) begin
      if (rec_q.size() > 0) rec_state = rec_q.pop_front();
      else chk("unexpected_strobe", 32'd1, 32'd0);
    end
    if (!reset) begin
      if (rec_reset) clr_seen = 1'b1;
      chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (sym_pend) chk("rec_sym_hold", 32'(rec_sym), 32'(held_sym));
      sym_pend = 1'b0;
      if (rec_strobe) begin
        chk("strobe_gap", 32'(prev_strobe), 32'd0);
        chk("clear_before_strobe", 32'(clr_seen), 32'd1);
        if (exp_sym.size() > 0) begin
          held_sym = exp_sym.pop_front();
          chk("rec_sym", 32'(rec_sym), 32'(held_sym));
          sym_pend = 1'b1;
        end else chk("strobe_sym_queue", 32'd1, 32'd0);
      end
      if (res_valid) begin
        if (exp_res.size() > 0) begin
          held_res = exp_res.pop_front();
          chk("res_ch", 32'(res_ch), 32'(held_res[11]));
          chk("res_code", 32'(res_code), 32'(held_res[10:8]));
          chk("res_count", 32'(res_count), 32'(held_res[7:0]));
          held_ok = 1'b1;
        end else chk("unexpected_res_valid", 32'd1, 32'd0);
        clr_seen = 1'b0;
      end else if (held_ok) begin
        chk("res_hold", 32'({res_ch, res_code, res_count}), 32'(held_res));
      end
      prev_strobe = rec_strobe;
    end else begin
      held_ok = 1'b0;
      prev_strobe = 1'b0;
      sym_pend = 1'b0;
      clr_seen = 1'b0;
    end
  end

  // Present one symbol and return on the falling edge after it is accepted.
  task automatic send(input logic ch, input logic [6:0] s, input logic l);
    logic ok;
    if (ch) begin req1_valid = 1'b1; req1_sym = s; req1_last = l; end
    else    begin req0_valid = 1'b1; req0_sym = s; req0_last = l; end
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (ch ? req1_ready : req0_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("handshake_budget", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input logic ch);
    if (ch) begin req1_valid = 1'b0; req1_last = 1'b0; end
    else    begin req0_valid = 1'b0; req0_last = 1'b0; end
  endtask

  task automatic wait_res();
    for (int k = 0; k < 300 && exp_res.size() > 0; k++) @(negedge clk);
    chk("result_arrived", 32'(exp_res.size()), 32'd0);
  endtask

  task automatic wait_pulse(output int k);
    for (k = 1; k < 60; k++) begin
      @(negedge clk);
      if (res_valid) return;
    end
  endtask

  task automatic set_sess(input int i, input logic ch, input logic [2:0] n, input logic [2:0] ns,
                          input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                          input logic [3:0] t0, input logic [3:0] t1,
                          input logic [2:0] code, input logic [7:0] cnt);
    tbl[i] = '{ch: ch, n: n, ns: ns, s0: s0, s1: s1, s2: s2, t0: t0, t1: t1, code: code, cnt: cnt};
  endtask

  task automatic push_sess(input int i);
    exp_res.push_back({tbl[i].ch, tbl[i].code, tbl[i].cnt});
    if (tbl[i].ns > 0) begin exp_sym.push_back(tbl[i].s0); rec_q.push_back(tbl[i].t0); end
    if (tbl[i].ns > 1) begin exp_sym.push_back(tbl[i].s1); rec_q.push_back(tbl[i].t1); end
  endtask

  task automatic drive_sess(input int i);
    logic [6:0] s;
    for (int j = 0; j < int'(tbl[i].n); j++) begin
      s = (j == 0) ? tbl[i].s0 : (j == 1) ? tbl[i].s1 : tbl[i].s2;
      send(tbl[i].ch, s, j == int'(tbl[i].n) - 1);
    end
    idle(tbl[i].ch);
  endtask

  initial begin
    int k;
    //        idx ch  n  ns  s0     s1     s2     t0       t1       code    cnt
    set_sess(0, 0, 2, 2, 7'h58, 7'h32, 7'h00, 4'b0001, 4'b1001, 3'b001, 8'd2);
    set_sess(1, 1, 2, 2, 7'h28, 7'h23, 7'h00, 4'b0100, 4'b1010, 3'b010, 8'd2);
    set_sess(2, 0, 3, 2, 7'h58, 7'h58, 7'h6B, 4'b0001, 4'b1000, 3'b011, 8'd2);
    set_sess(3, 0, 1, 1, 7'h4F, 7'h00, 7'h00, 4'b0011, 4'b0000, 3'b100, 8'd1);
    set_sess(4, 1, 1, 1, 7'h11, 7'h00, 7'h00, 4'b1111, 4'b0000, 3'b100, 8'd1);

    repeat (3) @(negedge clk);
    chk("rst_rec_reset", 32'(rec_reset), 32'd1);
    chk("rst_outputs", 32'({req0_ready, req1_ready, rec_strobe, res_valid, res_ch, res_code}), 32'd0);
    chk("rst_sym_count", 32'({rec_sym, res_count}), 32'd0);

    // both channels request on the first cycle out of reset: ch0 first, then ch1
    push_sess(0);
    push_sess(1);
    #1 reset = 1'b0;
    fork
      drive_sess(0);
      drive_sess(1);
    join
    wait_res();

    // ch0 goes quiet mid-session: timeout after 16 idle FEED cycles
    exp_res.push_back({1'b0, 3'b101, 8'd1});
    exp_sym.push_back(7'h58);
    rec_q.push_back(4'b0001);
    send(1'b0, 7'h58, 1'b0);
    idle(1'b0);
    wait_pulse(k);
    chk("feed_timeout_latency", 32'(k), 32'd18);
    wait_res();

    for (int i = 0; i < 5; i++) begin
      push_sess(i);
      drive_sess(i);
      wait_res();
    end

    // verdict reached without last, then silence: timeout replaces the accept code
    exp_res.push_back({1'b0, 3'b101, 8'd1});
    exp_sym.push_back(7'h58);
    rec_q.push_back(4'b1001);
    send(1'b0, 7'h58, 1'b0);
    idle(1'b0);
    wait_pulse(k);
    chk("drain_timeout_latency", 32'(k), 32'd18);
    wait_res();

    // reset lands during STROBE: session dropped, no result
    exp_sym.push_back(7'h58);
    rec_q.push_back(4'b0001);
    send(1'b0, 7'h58, 1'b0);
    chk("in_strobe", 32'(rec_strobe), 32'd1);
    #1 reset = 1'b1;
    idle(1'b0);
    @(negedge clk);
    chk("abort_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("abort_rec_reset", 32'(rec_reset), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    push_sess(0);
    drive_sess(0);
    wait_res();

    repeat (4) @(negedge clk);
    chk("sym_queue_empty", 32'(exp_sym.size()), 32'd0);
    chk("rec_queue_empty", 32'(rec_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

endmodule

// File: doc/recognizer_arbiter.md
RECOGNIZER_ARBITER -- requirements
Module: recognizer_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the number of idle cycles allowed mid-session before abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N presents a symbol.
REQ-005 req0_sym / req1_sym  input  7  symbol code from requester N.
REQ-006 req0_last / req1_last  input  1  the presented symbol is the final one of the session.
REQ-007 req0_ready / req1_ready  output  1  symbol accepted when valid and ready are both high on a clock edge.
REQ-008 rec_sym  output  7  symbol driven to the recognizer's 7 data inputs.
REQ-009 rec_strobe  output  1  recognizer symbol-valid strobe.
REQ-010 rec_reset  output  1  recognizer clear.
REQ-011 rec_state  input  4  recognizer state: 0000-0101 in progress, 1001 accept-A, 1010 accept-B, 1000 reject.
REQ-012 res_valid  output  1  one-cycle result pulse.
REQ-013 res_ch  output  1  channel the result belongs to.
REQ-014 res_code  output  3  result: 001 accept-A, 010 accept-B, 011 reject, 100 incomplete, 101 timeout.
REQ-015 res_count  output  8  symbols delivered to the recognizer in the session, saturating at 255.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, FEED, STROBE, CHECK, DRAIN, REPORT.
REQ-017 IDLE: if any reqN_valid, grant one channel: on a tie choose the channel not served last, with ch0 preferred after reset; go to CLEAR; the grant SHALL be held until REPORT.
REQ-018 CLEAR: rec_reset=1 for exactly one cycle; clear res_count and the timeout counter; go to FEED.
REQ-019 FEED: ready=1 on the granted channel only; on handshake, register sym into rec_sym, record last, increment res_count with saturation, and go to STROBE.
REQ-020 STROBE: rec_strobe=1 for exactly one cycle; rec_sym SHALL stay stable from STROBE through CHECK.
REQ-021 CHECK: rec_strobe=0; sample rec_state.
REQ-022 In CHECK, 1001, 1010 or 1000 SHALL set the code to 001, 010 or 011 respectively, and the FSM SHALL go to REPORT if last is set, else to DRAIN.
REQ-023 In CHECK, a non-terminal state with last set SHALL give code 100 and go to REPORT; otherwise the FSM SHALL return to FEED.
REQ-024 Each strobe pulse SHALL be followed by at least one strobe-low cycle, so at most one symbol is delivered per 3 cycles.
REQ-025 DRAIN: ready=1 on the granted channel; accepted symbols are discarded with no strobe and no res_count change; go to REPORT on the handshake with last=1.
REQ-026 Timeout: in FEED or DRAIN, count consecutive cycles with granted valid=0, and reset the count on valid=1.
REQ-027 On reaching TIMEOUT, code=101 and the FSM SHALL go to REPORT; a code already set in CHECK SHALL be overwritten by 101 if the timeout occurs in DRAIN.
REQ-028 REPORT: res_valid=1 for one cycle with res_ch, res_code and res_count stable; record the served channel for fairness; go to IDLE.
REQ-029 res_ch, res_code and res_count SHALL hold their values until the next REPORT.
REQ-030 The non-granted channel's ready SHALL be 0 in all states; both readys SHALL be 0 in IDLE, CLEAR, STROBE, CHECK and REPORT.
REQ-031 A rec_state value outside the listed codes SHALL be treated as non-terminal.

Reset
REQ-032 While reset=1, all outputs SHALL be 0 except rec_reset=1; the FSM SHALL be in IDLE, counters 0, and the fairness pointer set so that ch0 is preferred.
REQ-033 Reset asserted mid-session SHALL abort with no res_valid pulse; the session is not resumed.

Verification
REQ-034 ch0 sends 58h, then 32h with last=1 -> two strobes; rec_state 0001, then 1001; res_valid with ch=0, code=001, count=2.
REQ-035 ch1 sends 28h, then 23h with last=1 -> rec_state 0100, then 1010; res ch=1, code=010, count=2.
REQ-036 ch0 sends 58h, 58h, then 6Bh with last=1 -> reject after the 2nd symbol; the 3rd symbol is accepted with no strobe; code=011, count=2.
REQ-037 Both valids high on the first cycle after reset -> ch0 session completes first, then ch1; the CLEAR pulse precedes each session's first strobe.
REQ-038 ch0 sends 58h without last, then valid=0 for 16 cycles -> code=101, count=1; ch0 sends 4Fh with last=1 -> code=100.
REQ-039 reset asserted in STROBE -> next cycle all readys 0, rec_reset=1, no res_valid; normal sessions resume after release.
